// File: rtl/shift_seq_ctrl.sv
// Sequencer for a downstream shift register: load pulse, DIV-paced shift train, done pulse.
// Optional `abort` input when SEQ_ABORT_EN is defined.
module shift_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 1,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CW-1:0]    in_shamt,
`ifdef SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] sr_data,
   output logic             load,
   output logic             shift,
   output logic             done,
   output logic             busy,
   output logic [CW-1:0]    bit_cnt
);

   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_RELOAD = DW'((DIV > 1) ? DIV - 2 : 0);
   localparam logic [CW-1:0] N_MAX = CW'(WIDTH);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] n_shift;
   logic [DW-1:0] div_cnt;
   logic          abort_req;

`ifdef SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Outputs are registered alongside the state so each one is a decode of the state it enters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         in_ready <= 1'b1;
         load     <= 1'b0;
         shift    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         sr_data  <= '0;
         bit_cnt  <= '0;
         n_shift  <= '0;
         div_cnt  <= '0;
      end else begin
         load  <= 1'b0;
         shift <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= LOAD;
                  load     <= 1'b1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  sr_data  <= in_data;
                  n_shift  <= (in_shamt > N_MAX) ? N_MAX : in_shamt;
                  bit_cnt  <= '0;
               end
            end
            LOAD: begin
               if (abort_req || n_shift == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (DIV == 1) begin
                  state <= SHIFT;
                  shift <= 1'b1;
               end else begin
                  state   <= WAIT;
                  div_cnt <= DIV_RELOAD;
               end
            end
            WAIT: begin
               if (abort_req) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (div_cnt == '0) begin
                  state <= SHIFT;
                  shift <= 1'b1;
               end else begin
                  div_cnt <= div_cnt - DW'(1);
               end
            end
            SHIFT: begin
               bit_cnt <= bit_cnt + CW'(1);
               if (abort_req || (bit_cnt + CW'(1)) == n_shift) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (DIV == 1) begin
                  state <= SHIFT;
                  shift <= 1'b1;
               end else begin
                  state   <= WAIT;
                  div_cnt <= DIV_RELOAD;
               end
            end
            DONE: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller that sits directly upstream of the parameterised shift register and drives its `load`, `shift` and `done` controls and its `data_in` bus. It accepts one word per transaction over a valid/ready handshake, together with a shift amount. It then issues one load pulse, a paced train of shift pulses, and a final done pulse, so the downstream register presents the shifted word on its output.

## Interface
- `WIDTH`, default 8: data width; must match the downstream register.
- `DIV`, default 1: clock cycles between successive control pulses; must be ≥1.
- `CW`, default `$clog2(WIDTH+1)`: width of shift-amount and count fields (derived).
- `clk`, input, 1: the block's only clock; rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: upstream word and shift amount are valid.
- `in_ready`, output, 1: block can accept a transaction.
- `in_data`, input, WIDTH: word to be loaded.
- `in_shamt`, input, CW: number of left shifts requested.
- `sr_data`, output, WIDTH: drives the register's `data_in`; holds the captured word.
- `load`, output, 1: one-cycle load pulse.
- `shift`, output, 1: one-cycle shift pulse.
- `done`, output, 1: one-cycle pulse that releases the result to the register outputs.
- `busy`, output, 1: transaction in progress.
- `bit_cnt`, output, CW: shifts issued so far in the current transaction.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - LOAD: `load`=1.
  - WAIT: pacing.
  - SHIFT: `shift`=1.
  - DONE: `done`=1.
- `load`, `shift`, `done` and `in_ready` are pure state decodes. At most one of `load`/`shift`/`done` is high in any cycle.
- IDLE → LOAD on `in_valid & in_ready`:
  - capture `in_data` into `sr_data`;
  - capture N = min(`in_shamt`, WIDTH);
  - clear `bit_cnt`.
- LOAD → DONE if N=0. Otherwise LOAD → SHIFT if DIV=1, else → WAIT with the divider loaded to DIV-2.
- WAIT counts down to 0, then → SHIFT.
- SHIFT increments `bit_cnt`:
  - if the new `bit_cnt` = N → DONE;
  - else → SHIFT (DIV=1) or → WAIT with the divider reloaded to DIV-2.
- DONE → IDLE unconditionally.
- `busy`=1 in every state except IDLE.
- `in_ready`=0 outside IDLE. `in_valid` is ignored there, and a held word is accepted only after returning to IDLE.
- `sr_data` is stable from capture until the next accepted transaction.
- `in_shamt` > WIDTH is clamped to WIDTH. The result is then all-zero.

## Timing
- Reset values, applied immediately and asynchronously:
  - state IDLE;
  - `in_ready`=1;
  - `load`=`shift`=`done`=`busy`=0;
  - `sr_data`=0, `bit_cnt`=0.
- Cycle 0 is the cycle in which the handshake is sampled.
- `load` is high in cycle 1.
- Shift k (k=1..N) is high in cycle 1+k·DIV.
- `done` is high in cycle 2+N·DIV.
- IDLE is re-entered in cycle 3+N·DIV, with `in_ready`=1 in that cycle.
- Transaction period is 3+N·DIV cycles. N=0 gives `done` in cycle 2 and no shift pulses.
- Reset asserted mid-transaction:
  - aborts with no `done` pulse;
  - the captured word is discarded;
  - the downstream register must be reset by the same `reset` net, inverted to its active-low input at the top level.

## Configuration
- `SEQ_ABORT_EN` defined:
  - adds input port `abort` (1 bit, active-high).
  - `abort` sampled high in LOAD, WAIT or SHIFT forces → DONE on the next edge.
  - No further `shift` pulses are issued, and `done` pulses once with the partially shifted result.
  - `bit_cnt` holds the number of shifts actually issued.
  - `abort` is ignored in IDLE and DONE.
- `SEQ_ABORT_EN` undefined: no `abort` port; every accepted transaction runs to completion.

## Test plan
- WIDTH=8, DIV=1, `in_data`=0xA5, `in_shamt`=3 → `load` in cycle 1, `shift` in cycles 2, 3 and 4, `done` in cycle 5, register output 0x28, `bit_cnt`=3.
- `in_shamt`=0, with `in_valid` held high throughout → `load` in cycle 1, `done` in cycle 2, no `shift`; second transaction accepted in cycle 3, not earlier.
- DIV=4, `in_data`=0x01, `in_shamt`=2 → `shift` in cycles 5 and 9, `done` in cycle 10, register output 0x04, `in_ready` high in cycle 11.
- WIDTH=8, DIV=1, `in_shamt`=8, `in_data`=0xFF (clamp boundary) → 8 shift pulses, `done` in cycle 10, output 0x00; repeat with a larger value (clamp) → identical response.
- Reset asserted during WAIT (DIV=4, `in_shamt`=3, reset in cycle 6) → all outputs at reset values in the same cycle, no `done`, `in_ready`=1 after release.
- With `SEQ_ABORT_EN`: DIV=2, `in_data`=0x81, `in_shamt`=5, `abort` in cycle 4 → shift only in cycle 3, `done` in cycle 5, output 0x02, `bit_cnt`=1.
